ula_seq: RTL and testbench

//  Parametrised, registered successor of the 4-op combinational ULA.

---
 rtl/ula_seq.sv | 189 ++++++++++++++++++
 tb/tb_ula_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_seq.sv
// Registered ALU with flags, sticky overflow, valid/ready handshakes and an
// iterative shift-add signed multiplier (one partial product per cycle).
module ula_seq #(
  parameter int NUM_BITS = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] A,
  input  logic [NUM_BITS-1:0] B,
  input  logic [2:0]          F,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_BITS-1:0] Saida,
  output logic                Flag_Z,
  output logic                Flag_N,
  output logic                Flag_C,
  output logic                Flag_V,
  output logic                sticky_v,
  input  logic                clear_sticky
);

  localparam int MSB = NUM_BITS - 1;
  localparam int CW  = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic {IDLE, MUL} state_t;

  // Single-cycle ops; returns {C, V, result}.
  function automatic logic [NUM_BITS+1:0] alu_op(input logic [NUM_BITS-1:0] a,
                                                 input logic [NUM_BITS-1:0] b,
                                                 input logic [2:0]          f);
    logic signed [NUM_BITS-1:0] sa;
    logic signed [NUM_BITS-1:0] sb;
    logic [NUM_BITS:0]          sum;
    logic [NUM_BITS-1:0]        r;
    logic                       c;
    logic                       v;
    sa  = a;
    sb  = b;
    sum = '0;
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (f)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        r   = sum[MSB:0];
        c   = sum[NUM_BITS];
        v   = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
      end
      OP_SUB: begin
        sum = {1'b0, a} + {1'b0, ~b} + (NUM_BITS+1)'(1);
        r   = sum[MSB:0];
        c   = sum[NUM_BITS];
        v   = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]);
      end
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = (sa < sb) ? NUM_BITS'(1) : '0;
      OP_PASS: r = a;
      default: r = a;
    endcase
    return {c, v, r};
  endfunction

  function automatic logic [NUM_BITS-1:0] magnitude(input logic [NUM_BITS-1:0] x);
    return x[MSB] ? (~x + NUM_BITS'(1)) : x;
  endfunction

  // Applies the product sign and flags results outside the signed NUM_BITS range; returns {V, result}.
  function automatic logic [NUM_BITS:0] mul_fix(input logic [2*NUM_BITS-1:0] mag,
                                                input logic                  neg);
    logic signed [2*NUM_BITS-1:0] p;
    logic                         v;
    p = neg ? -$signed(mag) : $signed(mag);
    v = (p[2*NUM_BITS-1:MSB] != {(NUM_BITS+1){p[MSB]}});
    return {v, p[MSB:0]};
  endfunction

  state_t                  state;
  logic [CW-1:0]           cnt_p0;
  logic [NUM_BITS-1:0]     ma_p0;
  logic [NUM_BITS-1:0]     mb_p0;
  logic                    neg_p0;
  logic [2*NUM_BITS-1:0]   acc_p0;
  logic [2*NUM_BITS-1:0]   acc_nxt;
  logic                    accept;
  logic                    mul_done;
  logic                    load;
  logic [NUM_BITS+1:0]     alu_r;
  logic [NUM_BITS:0]       mul_r;
  logic [NUM_BITS-1:0]     res;
  logic                    res_c;
  logic                    res_v;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign mul_done = (state == MUL) && (cnt_p0 == LAST);
  assign load     = (accept && (F != OP_MUL)) || mul_done;

  // Stage p0: magnitude shift-add, one multiplier bit per cycle
  assign acc_nxt = acc_p0 + (mb_p0[cnt_p0] ? ({{NUM_BITS{1'b0}}, ma_p0} << cnt_p0) : '0);
  assign alu_r   = alu_op(A, B, F);
  assign mul_r   = mul_fix(acc_nxt, neg_p0);

  always_comb begin
    res   = alu_r[MSB:0];
    res_c = alu_r[NUM_BITS+1];
    res_v = alu_r[NUM_BITS];
    if (mul_done) begin
      res   = mul_r[MSB:0];
      res_c = 1'b0;
      res_v = mul_r[NUM_BITS];
    end
  end

  always_ff @(posedge clock) begin
    if (accept && (F == OP_MUL)) begin
      ma_p0  <= magnitude(A);
      mb_p0  <= magnitude(B);
      neg_p0 <= A[MSB] ^ B[MSB];
      acc_p0 <= '0;
    end else if (state == MUL) begin
      acc_p0 <= acc_nxt;
    end
  end

  // Stage p1: output register, flags, sticky overflow and sequencing
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt_p0    <= '0;
      out_valid <= 1'b0;
      Saida     <= '0;
      Flag_Z    <= 1'b0;
      Flag_N    <= 1'b0;
      Flag_C    <= 1'b0;
      Flag_V    <= 1'b0;
      sticky_v  <= 1'b0;
    end else begin
      if (load) begin
        Saida     <= res;
        Flag_Z    <= (res == '0);
        Flag_N    <= res[MSB];
        Flag_C    <= res_c;
        Flag_V    <= res_v;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (clear_sticky) begin
        sticky_v <= 1'b0;
      end else if (load && res_v) begin
        sticky_v <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (accept && (F == OP_MUL)) begin
            state  <= MUL;
            cnt_p0 <= '0;
          end
        end
        MUL: begin
          if (cnt_p0 == LAST) begin
            state <= IDLE;
          end else begin
            cnt_p0 <= cnt_p0 + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// Bench for ula_seq: directed scenarios plus randomized traffic, scored
// against an integer-arithmetic reference model and a queue of expected results.
module tb_ula_seq;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   F;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Saida;
  logic         Flag_Z;
  logic         Flag_N;
  logic         Flag_C;
  logic         Flag_V;
  logic         sticky_v;
  logic         clear_sticky;

  always #5 clock = ~clock;

  ula_seq #(.NUM_BITS(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .A            (A),
    .B            (B),
    .F            (F),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .Saida        (Saida),
    .Flag_Z       (Flag_Z),
    .Flag_N       (Flag_N),
    .Flag_C       (Flag_C),
    .Flag_V       (Flag_V),
    .sticky_v     (sticky_v),
    .clear_sticky (clear_sticky)
  );

  typedef struct {
    logic [7:0] res;
    logic       z;
    logic       n;
    logic       c;
    logic       v;
    int         due;
  } exp_t;

  exp_t q[$];
  int   n_checks   = 0;
  int   n_errors   = 0;
  int   cyc        = 0;
  logic exp_ov     = 1'b0;
  logic exp_sticky = 1'b0;
  logic mul_active = 1'b0;
  int   mul_k      = 0;
  logic mul_v      = 1'b0;
  logic last_acc   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f);
    exp_t e;
    int sa, sb, ua, ub, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    e.c = 1'b0;
    e.v = 1'b0;
    e.due = 0;
    case (f)
      3'd0: r = int'(a & b);
      3'd1: r = int'(a | b);
      3'd2: begin r = sa + sb; e.c = ((ua + ub) > 255); e.v = (r > 127) || (r < -128); end
      3'd3: begin r = sa - sb; e.c = (ua >= ub);        e.v = (r > 127) || (r < -128); end
      3'd4: r = int'(a ^ b);
      3'd5: r = (sa < sb) ? 1 : 0;
      3'd6: begin r = sa * sb; e.v = (r > 127) || (r < -128); end
      default: r = ua;
    endcase
    e.res = r[7:0];
    e.z = (e.res == 8'h00);
    e.n = e.res[7];
    return e;
  endfunction

  function automatic logic [7:0] rnd_opnd();
    case ($urandom_range(0, 9))
      0: return 8'h80;
      1: return 8'h7f;
      2: return 8'hff;
      3: return 8'h00;
      4: return 8'h01;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic obs();
    @(negedge clock);
    cyc++;
    if (q.size() > 0) exp_ov = (cyc >= q[0].due);
    else exp_ov = 1'b0;
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("sticky_v", 32'(sticky_v), 32'(exp_sticky));
    if (exp_ov && out_valid) begin
      chk("saida", 32'(Saida), 32'(q[0].res));
      chk("flags_zncv", 32'({Flag_Z, Flag_N, Flag_C, Flag_V}),
          32'({q[0].z, q[0].n, q[0].c, q[0].v}));
    end
  endtask

  task automatic drv(input logic v, input logic [7:0] a, input logic [7:0] b,
                     input logic [2:0] f, input logic ordy, input logic clr);
    logic busy, exp_ir, acc, ld, ld_v;
    exp_t m;
    in_valid = v; A = a; B = b; F = f; out_ready = ordy; clear_sticky = clr;
    #1;
    busy   = mul_active && (cyc >= mul_k + 1) && (cyc <= mul_k + 8);
    exp_ir = !busy && (!exp_ov || ordy);
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    acc = v && exp_ir;
    if (exp_ov && ordy) q.delete(0);
    ld = 1'b0;
    ld_v = 1'b0;
    if (mul_active && (cyc == mul_k + 8)) begin
      ld = 1'b1; ld_v = mul_v; mul_active = 1'b0;
    end
    if (acc) begin
      m = model(a, b, f);
      if (f == 3'd6) begin
        m.due = cyc + 9; mul_active = 1'b1; mul_k = cyc; mul_v = m.v;
      end else begin
        m.due = cyc + 1; ld = 1'b1; ld_v = m.v;
      end
      q.push_back(m);
    end
    if (clr) exp_sticky = 1'b0;
    else if (ld && ld_v) exp_sticky = 1'b1;
    last_acc = acc;
  endtask

  task automatic cyc1(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] f, input logic ordy, input logic clr);
    obs();
    drv(v, a, b, f, ordy, clr);
  endtask

  initial begin
    logic       rv;
    logic [7:0] ra, rb;
    logic [2:0] rf;
    reset = 1'b0; in_valid = 1'b0; A = '0; B = '0; F = '0;
    out_ready = 1'b1; clear_sticky = 1'b0;
    @(negedge clock);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_saida", 32'(Saida), 32'd0);
    chk("reset_flags", 32'({Flag_Z, Flag_N, Flag_C, Flag_V}), 32'd0);
    chk("reset_sticky", 32'(sticky_v), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    reset = 1'b1;

    // ADD overflow and sticky set
    obs(); drv(1'b1, 8'd100, 8'd50, 3'd2, 1'b1, 1'b0);
    obs();
    chk("add_saida", 32'(Saida), 32'h96);
    chk("add_zncv", 32'({Flag_Z, Flag_N, Flag_C, Flag_V}), 32'b0101);
    chk("add_sticky", 32'(sticky_v), 32'd1);
    // SUB -128-1 then clear sticky
    drv(1'b1, 8'h80, 8'h01, 3'd3, 1'b1, 1'b0);
    obs();
    chk("sub_saida", 32'(Saida), 32'h7f);
    chk("sub_zncv", 32'({Flag_Z, Flag_N, Flag_C, Flag_V}), 32'b0011);
    drv(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b1);
    obs();
    chk("clear_sticky", 32'(sticky_v), 32'd0);
    // MUL 12*-3 with an XOR held at the input while busy
    drv(1'b1, 8'd12, 8'hfd, 3'd6, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc1(1'b1, 8'h0f, 8'h33, 3'd4, 1'b1, 1'b0);
      chk("mul_busy_in_ready", 32'(in_ready), 32'd0);
    end
    obs();
    chk("mul_latency_valid", 32'(out_valid), 32'd1);
    chk("mul_saida", 32'(Saida), 32'hdc);
    chk("mul_v", 32'(Flag_V), 32'd0);
    drv(1'b1, 8'h0f, 8'h33, 3'd4, 1'b1, 1'b0);
    obs();
    chk("xor_saida", 32'(Saida), 32'h3c);
    // MUL 16*16 overflows to zero
    drv(1'b1, 8'd16, 8'd16, 3'd6, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cyc1(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0);
    obs();
    chk("mul16_saida", 32'(Saida), 32'h00);
    chk("mul16_zv", 32'({Flag_Z, Flag_V}), 32'b11);
    drv(1'b1, 8'hff, 8'h01, 3'd5, 1'b1, 1'b0);
    obs();
    chk("slt_saida", 32'(Saida), 32'h01);
    // Backpressure: AND result held for 5 cycles
    drv(1'b1, 8'hf0, 8'h3c, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      obs();
      chk("hold_saida", 32'(Saida), 32'h30);
      drv(1'b1, 8'h11, 8'h22, 3'd1, 1'b0, 1'b0);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    obs();
    drv(1'b1, 8'h11, 8'h22, 3'd1, 1'b1, 1'b0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    obs();
    chk("or_saida", 32'(Saida), 32'h33);
    // Reset during MUL cycle 4
    drv(1'b1, 8'd5, 8'd7, 3'd6, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc1(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0);
    obs();
    reset = 1'b0; in_valid = 1'b0;
    #1;
    chk("midmul_out_valid", 32'(out_valid), 32'd0);
    chk("midmul_flags", 32'({Flag_Z, Flag_N, Flag_C, Flag_V}), 32'd0);
    chk("midmul_saida", 32'(Saida), 32'd0);
    chk("midmul_sticky", 32'(sticky_v), 32'd0);
    @(negedge clock);
    cyc++;
    reset = 1'b1;
    q.delete();
    mul_active = 1'b0; exp_sticky = 1'b0; exp_ov = 1'b0;
    for (int i = 0; i < 12; i++) cyc1(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0);

    // Randomized traffic with random backpressure and sticky clears
    rv = 1'b0; ra = '0; rb = '0; rf = '0; last_acc = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      obs();
      if (!(rv && !last_acc)) begin
        rv = ($urandom_range(0, 9) < 7);
        ra = rnd_opnd();
        rb = rnd_opnd();
        rf = 3'($urandom_range(0, 7));
      end
      drv(rv, ra, rb, rf, ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
    end
    for (int i = 0; i < 20; i++) cyc1(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0);
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
